control_sequencer: RTL and testbench

- Hardwired control unit that drives the datapath's register-enable and bus-source strobes.
- Sequences fetch (T0–T2) and per-instruction execute steps (T3–T7) from IR[31:27].
- Waits on a memory ready handshake.
- Drives one-hot bus-out strobes that the datapath's bus encoder converts into the BusMux select.

---
 rtl/cpu_ctrl_pkg.sv | 39 +++
 rtl/ctrl_opcode_decode.sv | 44 ++++
 rtl/control_sequencer.sv | 171 +++++++++++++++++
 tb/tb_control_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, ALU-operation, state and instruction-class definitions for
// the hardwired control sequencer.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  // ALU operation codes share the encoding of the register-form opcodes
  localparam logic [4:0] ALU_ADD = OP_ADD;
  localparam logic [4:0] ALU_SUB = OP_SUB;
  localparam logic [4:0] ALU_AND = OP_AND;
  localparam logic [4:0] ALU_OR  = OP_OR;

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE, CL_ALU_REG, CL_ALU_IMM, CL_LDI, CL_LD, CL_ST, CL_BR,
    CL_JR, CL_MFHI, CL_MFLO, CL_IN, CL_OUT, CL_HALT
  } iclass_t;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode decoder: instruction class plus the ALU operation the
// execute steps should request. Non-ALU classes default to ADD, which is what
// address and branch-target arithmetic needs.
module ctrl_opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass,
  output logic [4:0] alu_op
);

  // opcode -> class / ALU op
  always_comb begin
    iclass = CL_NONE;
    alu_op = ALU_ADD;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        iclass = CL_ALU_REG;
        alu_op = opcode;
      end
      OP_ADDI: iclass = CL_ALU_IMM;
      OP_ANDI: begin
        iclass = CL_ALU_IMM;
        alu_op = ALU_AND;
      end
      OP_ORI: begin
        iclass = CL_ALU_IMM;
        alu_op = ALU_OR;
      end
      OP_LDI:  iclass = CL_LDI;
      OP_LD:   iclass = CL_LD;
      OP_ST:   iclass = CL_ST;
      OP_BR:   iclass = CL_BR;
      OP_JR:   iclass = CL_JR;
      OP_MFHI: iclass = CL_MFHI;
      OP_MFLO: iclass = CL_MFLO;
      OP_IN:   iclass = CL_IN;
      OP_OUT:  iclass = CL_OUT;
      OP_HALT: iclass = CL_HALT;
      default: iclass = CL_NONE;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2), per-class execute (T3-T7), memory
// ready handshake, and one-hot bus-source strobes for the datapath encoder.
//
// state | meaning
// RST   | held in reset, all outputs low
// T0    | PC to MAR, start PC+1
// T1    | PC update, memory read of instruction (waits on mem_ready)
// T2    | MDR to IR, class decided from opcode
// T3-T7 | execute steps for the decoded class
// HALT  | stopped until clr asserts
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] IR,
  input  logic              CON_FF,
  input  logic              mem_ready,
  output logic PC_out, ZHI_out, ZLOW_out, MDR_out, HI_out, LO_out,
  output logic inPort_out, C_out, Rout, BAout,
  output logic PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, HI_in, LO_in,
  output logic outPort_in, CON_in, Rin,
  output logic Gra, Grb, Grc,
  output logic IncPC,
  output logic Read, Write,
  output logic [4:0] alu_op,
  output logic run
);

  state_t           state;
  logic             t1_wait;
  logic [OPC_W-1:0] opcode;
  iclass_t          iclass;
  logic [4:0]       dec_alu;

  // Operand fields are routed by the datapath via Gra/Grb/Grc; only the
  // opcode matters here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[DATA_W-OPC_W-1:0];

  assign opcode = IR[DATA_W-1 -: OPC_W];

  ctrl_opcode_decode u_decode (
    .opcode (opcode),
    .iclass (iclass),
    .alu_op (dec_alu)
  );

  // State register; t1_wait marks repeat T1 cycles so PC loads only once
  always_ff @(posedge clk) begin
    if (!clr) begin
      state   <= RST;
      t1_wait <= 1'b0;
    end else begin
      t1_wait <= (state == T1);
      unique case (state)
        RST: state <= T0;
        T0:  state <= T1;
        T1:  state <= mem_ready ? T2 : T1;
        T2: begin
          if (iclass == CL_HALT)      state <= HALT;
          else if (iclass == CL_NONE) state <= T0;
          else                        state <= T3;
        end
        T3: begin
          case (iclass)
            CL_ALU_REG, CL_ALU_IMM, CL_LDI, CL_LD, CL_ST, CL_BR: state <= T4;
            default: state <= T0;
          endcase
        end
        T4: state <= T5;
        T5: begin
          case (iclass)
            CL_LD, CL_ST, CL_BR: state <= T6;
            default:             state <= T0;
          endcase
        end
        T6: begin
          case (iclass)
            CL_LD:   state <= mem_ready ? T7 : T6;
            CL_ST:   state <= T7;
            default: state <= T0;
          endcase
        end
        T7: begin
          if (iclass == CL_ST && !mem_ready) state <= T7;
          else                               state <= T0;
        end
        HALT:    state <= HALT;
        default: state <= RST;
      endcase
    end
  end

  // Strobe decode from state, instruction class and CON_FF
  always_comb begin
    {PC_out, ZHI_out, ZLOW_out, MDR_out, HI_out, LO_out, inPort_out,
     C_out, Rout, BAout} = '0;
    {PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, HI_in, LO_in,
     outPort_in, CON_in, Rin} = '0;
    {Gra, Grb, Grc, IncPC, Read, Write} = '0;
    alu_op = '0;
    run    = !(state == RST || state == HALT);
    case (state)
      T0: {PC_out, MAR_in, IncPC, Z_in} = '1;
      T1: begin
        {ZLOW_out, Read, MDR_in} = '1;
        PC_in = !t1_wait;
      end
      T2: {MDR_out, IR_in} = '1;
      T3: begin
        case (iclass)
          CL_ALU_REG, CL_ALU_IMM: {Grb, Rout, Y_in}       = '1;
          CL_LDI, CL_LD, CL_ST:   {Grb, BAout, Y_in}      = '1;
          CL_BR:                  {Gra, Rout, CON_in}     = '1;
          CL_JR:                  {Gra, Rout, PC_in}      = '1;
          CL_MFHI:                {HI_out, Gra, Rin}      = '1;
          CL_MFLO:                {LO_out, Gra, Rin}      = '1;
          CL_IN:                  {inPort_out, Gra, Rin}  = '1;
          CL_OUT:                 {Gra, Rout, outPort_in} = '1;
          default: ;
        endcase
      end
      T4: begin
        case (iclass)
          CL_ALU_REG: begin
            {Grc, Rout, Z_in} = '1;
            alu_op = dec_alu;
          end
          CL_ALU_IMM, CL_LDI, CL_LD, CL_ST: begin
            {C_out, Z_in} = '1;
            alu_op = dec_alu;
          end
          CL_BR: {PC_out, Y_in} = '1;
          default: ;
        endcase
      end
      T5: begin
        case (iclass)
          CL_ALU_REG, CL_ALU_IMM, CL_LDI: {ZLOW_out, Gra, Rin} = '1;
          CL_LD, CL_ST:                   {ZLOW_out, MAR_in}   = '1;
          CL_BR: begin
            {C_out, Z_in} = '1;
            alu_op = ALU_ADD;
          end
          default: ;
        endcase
      end
      T6: begin
        case (iclass)
          CL_LD:   {Read, MDR_in}      = '1;
          CL_ST:   {Gra, Rout, MDR_in} = '1;
          CL_BR:   if (CON_FF) {ZLOW_out, PC_in} = '1;
          default: ;
        endcase
      end
      T7: begin
        case (iclass)
          CL_LD:   {MDR_out, Gra, Rin} = '1;
          CL_ST:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer. Each table row is one
// clock cycle: inputs are driven just after the rising edge and outputs are
// compared on the falling edge.
module tb_control_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, CON_FF, mem_ready;
  logic [31:0] IR;
  logic PC_out, ZHI_out, ZLOW_out, MDR_out, HI_out, LO_out, inPort_out;
  logic C_out, Rout, BAout, PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in;
  logic HI_in, LO_in, outPort_in, CON_in, Rin, Gra, Grb, Grc, IncPC;
  logic Read, Write, run;
  logic [4:0] alu_op;

  control_sequencer #(.DATA_W(32), .OPC_W(5)) dut (
    .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .mem_ready(mem_ready),
    .PC_out(PC_out), .ZHI_out(ZHI_out), .ZLOW_out(ZLOW_out),
    .MDR_out(MDR_out), .HI_out(HI_out), .LO_out(LO_out),
    .inPort_out(inPort_out), .C_out(C_out), .Rout(Rout), .BAout(BAout),
    .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in),
    .MAR_in(MAR_in), .MDR_in(MDR_in), .HI_in(HI_in), .LO_in(LO_in),
    .outPort_in(outPort_in), .CON_in(CON_in), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC),
    .Read(Read), .Write(Write), .alu_op(alu_op), .run(run)
  );

  logic [27:0] sig;
  assign sig = {PC_out, ZHI_out, ZLOW_out, MDR_out, HI_out, LO_out,
                inPort_out, C_out, Rout, BAout, PC_in, IR_in, Y_in, Z_in,
                MAR_in, MDR_in, HI_in, LO_in, outPort_in, CON_in, Rin,
                Gra, Grb, Grc, IncPC, Read, Write, run};

  localparam logic [27:0] M_PC_OUT     = 28'h800_0000;
  localparam logic [27:0] M_ZLOW_OUT   = 28'h200_0000;
  localparam logic [27:0] M_MDR_OUT    = 28'h100_0000;
  localparam logic [27:0] M_HI_OUT     = 28'h080_0000;
  localparam logic [27:0] M_LO_OUT     = 28'h040_0000;
  localparam logic [27:0] M_INPORT_OUT = 28'h020_0000;
  localparam logic [27:0] M_C_OUT      = 28'h010_0000;
  localparam logic [27:0] M_ROUT       = 28'h008_0000;
  localparam logic [27:0] M_BAOUT      = 28'h004_0000;
  localparam logic [27:0] M_PC_IN      = 28'h002_0000;
  localparam logic [27:0] M_IR_IN      = 28'h001_0000;
  localparam logic [27:0] M_Y_IN       = 28'h000_8000;
  localparam logic [27:0] M_Z_IN       = 28'h000_4000;
  localparam logic [27:0] M_MAR_IN     = 28'h000_2000;
  localparam logic [27:0] M_MDR_IN     = 28'h000_1000;
  localparam logic [27:0] M_OUTPORT_IN = 28'h000_0200;
  localparam logic [27:0] M_CON_IN     = 28'h000_0100;
  localparam logic [27:0] M_RIN        = 28'h000_0080;
  localparam logic [27:0] M_GRA        = 28'h000_0040;
  localparam logic [27:0] M_GRB        = 28'h000_0020;
  localparam logic [27:0] M_GRC        = 28'h000_0010;
  localparam logic [27:0] M_INCPC      = 28'h000_0008;
  localparam logic [27:0] M_READ       = 28'h000_0004;
  localparam logic [27:0] M_WRITE      = 28'h000_0002;
  localparam logic [27:0] M_RUN        = 28'h000_0001;

  localparam logic [27:0] E_T0  = M_PC_OUT | M_MAR_IN | M_INCPC | M_Z_IN | M_RUN;
  localparam logic [27:0] E_T1F = M_ZLOW_OUT | M_PC_IN | M_READ | M_MDR_IN | M_RUN;
  localparam logic [27:0] E_T1W = M_ZLOW_OUT | M_READ | M_MDR_IN | M_RUN;
  localparam logic [27:0] E_T2  = M_MDR_OUT | M_IR_IN | M_RUN;
  localparam logic [27:0] E_RR3 = M_GRB | M_ROUT | M_Y_IN | M_RUN;
  localparam logic [27:0] E_RR4 = M_GRC | M_ROUT | M_Z_IN | M_RUN;
  localparam logic [27:0] E_IM4 = M_C_OUT | M_Z_IN | M_RUN;
  localparam logic [27:0] E_WB  = M_ZLOW_OUT | M_GRA | M_RIN | M_RUN;
  localparam logic [27:0] E_BA3 = M_GRB | M_BAOUT | M_Y_IN | M_RUN;
  localparam logic [27:0] E_MA5 = M_ZLOW_OUT | M_MAR_IN | M_RUN;

  typedef struct {
    string       name;
    logic        clr;
    logic [31:0] ir;
    logic        con_ff;
    logic        mem_ready;
    logic [27:0] sig;
    logic [4:0]  alu;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] cur_ir;
  int          checks = 0;
  int          errors = 0;

  task automatic add_row(input string n, input logic c, input logic cf,
                         input logic mr, input logic [27:0] s,
                         input logic [4:0] a);
    vec_t v;
    v.name = n; v.clr = c; v.ir = cur_ir; v.con_ff = cf;
    v.mem_ready = mr; v.sig = s; v.alu = a;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [31:0] ir);
    cur_ir = ir;
    add_row("fetch_t0", 1'b1, 1'b0, 1'b1, E_T0, 5'd0);
    add_row("fetch_t1", 1'b1, 1'b0, 1'b1, E_T1F, 5'd0);
    add_row("fetch_t2", 1'b1, 1'b0, 1'b1, E_T2, 5'd0);
  endtask

  task automatic check(input string n, input logic [27:0] es, input logic [4:0] ea);
    checks++;
    if (sig !== es) begin
      errors++;
      $display("FAIL %s strobes: got %h expected %h", n, sig, es);
    end
    checks++;
    if (alu_op !== ea) begin
      errors++;
      $display("FAIL %s alu_op: got %b expected %b", n, alu_op, ea);
    end
    checks++;
    if ($countones(sig[27:18]) > 1) begin
      errors++;
      $display("FAIL %s bus_onehot: got %b expected at most one set", n, sig[27:18]);
    end
  endtask

  task automatic step(input string n, input logic [27:0] es, input logic [4:0] ea);
    @(negedge clk);
    check(n, es, ea);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b0; IR = '0; CON_FF = 1'b0; mem_ready = 1'b0;
    cur_ir = 32'h1A2B_8000;

    // reset, release, then fetch with three wait cycles in T1
    add_row("rst0", 1'b0, 1'b0, 1'b0, 28'h0, 5'd0);
    add_row("rst1", 1'b0, 1'b0, 1'b0, 28'h0, 5'd0);
    add_row("rst_release", 1'b1, 1'b0, 1'b0, 28'h0, 5'd0);
    add_row("t0_after_rst", 1'b1, 1'b0, 1'b0, E_T0, 5'd0);
    add_row("t1_first", 1'b1, 1'b0, 1'b0, E_T1F, 5'd0);
    add_row("t1_wait1", 1'b1, 1'b0, 1'b0, E_T1W, 5'd0);
    add_row("t1_wait2", 1'b1, 1'b0, 1'b0, E_T1W, 5'd0);
    add_row("t1_done", 1'b1, 1'b0, 1'b1, E_T1W, 5'd0);
    add_row("t2", 1'b1, 1'b0, 1'b1, E_T2, 5'd0);
    add_row("add_t3", 1'b1, 1'b0, 1'b1, E_RR3, 5'd0);
    add_row("add_t4", 1'b1, 1'b0, 1'b1, E_RR4, 5'b00011);
    add_row("add_t5", 1'b1, 1'b0, 1'b1, E_WB, 5'd0);

    // add again, reset asserted for two cycles starting mid-T4
    add_fetch(32'h1A2B_8000);
    add_row("add_t3", 1'b1, 1'b0, 1'b1, E_RR3, 5'd0);
    add_row("add_t4_clr", 1'b0, 1'b0, 1'b1, E_RR4, 5'b00011);
    add_row("clr_mid", 1'b0, 1'b0, 1'b1, 28'h0, 5'd0);
    add_row("clr_release", 1'b1, 1'b0, 1'b1, 28'h0, 5'd0);

    add_fetch(32'h2000_0000);  // sub
    add_row("sub_t3", 1'b1, 1'b0, 1'b0, E_RR3, 5'd0);
    add_row("sub_t4", 1'b1, 1'b0, 1'b0, E_RR4, 5'b00100);
    add_row("sub_t5", 1'b1, 1'b0, 1'b0, E_WB, 5'd0);

    add_fetch(32'h6800_0000);  // andi
    add_row("andi_t3", 1'b1, 1'b0, 1'b1, E_RR3, 5'd0);
    add_row("andi_t4", 1'b1, 1'b0, 1'b1, E_IM4, 5'b00101);
    add_row("andi_t5", 1'b1, 1'b0, 1'b1, E_WB, 5'd0);

    add_fetch(32'h0800_0000);  // ldi
    add_row("ldi_t3", 1'b1, 1'b0, 1'b1, E_BA3, 5'd0);
    add_row("ldi_t4", 1'b1, 1'b0, 1'b1, E_IM4, 5'b00011);
    add_row("ldi_t5", 1'b1, 1'b0, 1'b1, E_WB, 5'd0);

    add_fetch(32'h1000_0000);  // st, memory slow by two cycles
    add_row("st_t3", 1'b1, 1'b0, 1'b0, E_BA3, 5'd0);
    add_row("st_t4", 1'b1, 1'b0, 1'b0, E_IM4, 5'b00011);
    add_row("st_t5", 1'b1, 1'b0, 1'b0, E_MA5, 5'd0);
    add_row("st_t6", 1'b1, 1'b0, 1'b0, M_GRA | M_ROUT | M_MDR_IN | M_RUN, 5'd0);
    add_row("st_t7_w0", 1'b1, 1'b0, 1'b0, M_WRITE | M_RUN, 5'd0);
    add_row("st_t7_w1", 1'b1, 1'b0, 1'b0, M_WRITE | M_RUN, 5'd0);
    add_row("st_t7_done", 1'b1, 1'b0, 1'b1, M_WRITE | M_RUN, 5'd0);

    add_fetch(32'h0000_0000);  // ld, memory slow by one cycle
    add_row("ld_t3", 1'b1, 1'b0, 1'b1, E_BA3, 5'd0);
    add_row("ld_t4", 1'b1, 1'b0, 1'b1, E_IM4, 5'b00011);
    add_row("ld_t5", 1'b1, 1'b0, 1'b0, E_MA5, 5'd0);
    add_row("ld_t6_w", 1'b1, 1'b0, 1'b0, M_READ | M_MDR_IN | M_RUN, 5'd0);
    add_row("ld_t6_done", 1'b1, 1'b0, 1'b1, M_READ | M_MDR_IN | M_RUN, 5'd0);
    add_row("ld_t7", 1'b1, 1'b0, 1'b1, M_MDR_OUT | M_GRA | M_RIN | M_RUN, 5'd0);

    add_fetch(32'h9000_0000);  // br, not taken
    add_row("br0_t3", 1'b1, 1'b0, 1'b1, M_GRA | M_ROUT | M_CON_IN | M_RUN, 5'd0);
    add_row("br0_t4", 1'b1, 1'b0, 1'b1, M_PC_OUT | M_Y_IN | M_RUN, 5'd0);
    add_row("br0_t5", 1'b1, 1'b0, 1'b1, E_IM4, 5'b00011);
    add_row("br0_t6", 1'b1, 1'b0, 1'b1, M_RUN, 5'd0);

    add_fetch(32'h9000_0000);  // br, taken
    add_row("br1_t3", 1'b1, 1'b1, 1'b1, M_GRA | M_ROUT | M_CON_IN | M_RUN, 5'd0);
    add_row("br1_t4", 1'b1, 1'b1, 1'b1, M_PC_OUT | M_Y_IN | M_RUN, 5'd0);
    add_row("br1_t5", 1'b1, 1'b1, 1'b1, E_IM4, 5'b00011);
    add_row("br1_t6", 1'b1, 1'b1, 1'b1, M_ZLOW_OUT | M_PC_IN | M_RUN, 5'd0);

    add_fetch(32'h9800_0000);
    add_row("jr_t3", 1'b1, 1'b0, 1'b1, M_GRA | M_ROUT | M_PC_IN | M_RUN, 5'd0);
    add_fetch(32'hB800_0000);
    add_row("mfhi_t3", 1'b1, 1'b0, 1'b1, M_HI_OUT | M_GRA | M_RIN | M_RUN, 5'd0);
    add_fetch(32'hC000_0000);
    add_row("mflo_t3", 1'b1, 1'b0, 1'b1, M_LO_OUT | M_GRA | M_RIN | M_RUN, 5'd0);
    add_fetch(32'hA800_0000);
    add_row("in_t3", 1'b1, 1'b0, 1'b1, M_INPORT_OUT | M_GRA | M_RIN | M_RUN, 5'd0);
    add_fetch(32'hB000_0000);
    add_row("out_t3", 1'b1, 1'b0, 1'b1, M_GRA | M_ROUT | M_OUTPORT_IN | M_RUN, 5'd0);
    add_fetch(32'hF800_0000);  // undefined opcode: no execute steps

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      clr       = vecs[i].clr;
      IR        = vecs[i].ir;
      CON_FF    = vecs[i].con_ff;
      mem_ready = vecs[i].mem_ready;
      step(vecs[i].name, vecs[i].sig, vecs[i].alu);
    end

    // halt: T2 goes straight to HALT, which holds until clr asserts
    clr = 1'b1; IR = 32'hD000_0000; CON_FF = 1'b0; mem_ready = 1'b1;
    step("undef_back_to_t0", E_T0, 5'd0);
    step("halt_t1", E_T1F, 5'd0);
    step("halt_t2", E_T2, 5'd0);
    for (int k = 0; k < 10; k++) step("halt_hold", 28'h0, 5'd0);
    clr = 1'b0;
    step("halt_clr", 28'h0, 5'd0);
    clr = 1'b1;
    step("halt_rst", 28'h0, 5'd0);
    step("halt_restart_t0", E_T0, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
